// File: rtl/game_ctl_if.sv
// Pong game controller port bundle: frame/control inputs and
// registered position, score and status outputs.
interface game_ctl_if;
    logic       vblnk;
    logic       start;
    logic       l_up;
    logic       l_dn;
    logic       r_up;
    logic       r_dn;
    logic [9:0] x_ball;
    logic [9:0] y_ball;
    logic [9:0] y_pad_left;
    logic [9:0] y_pad_right;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic [2:0] state;

    modport slave (
        input  vblnk, start, l_up, l_dn, r_up, r_dn,
        output x_ball, y_ball, y_pad_left, y_pad_right,
        output score_left, score_right, game_over, state
    );

    modport master (
        output vblnk, start, l_up, l_dn, r_up, r_dn,
        input  x_ball, y_ball, y_pad_left, y_pad_right,
        input  score_left, score_right, game_over, state
    );
endinterface

// File: rtl/game_ctl.sv
// Pong game controller: frame-ticked ball/pad motion, collision,
// scoring and serve/point/game-over sequencing.
module game_ctl #(
    parameter int HOR_PIXELS   = 1024,
    parameter int VER_PIXELS   = 768,
    parameter int BALL_SIZE    = 15,
    parameter int PAD_HEIGHT   = 145,
    parameter int PAD_WIDTH    = 15,
    parameter int X_PAD_LEFT   = 30,
    parameter int X_PAD_RIGHT  = 979,
    parameter int BALL_STEP    = 4,
    parameter int PAD_STEP     = 6,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 9
) (
    input logic       clk,
    input logic       rst_n,
    game_ctl_if.slave bus
);
    localparam int CMAX = (SERVE_FRAMES > POINT_FRAMES) ?
                          SERVE_FRAMES : POINT_FRAMES;
    localparam int CW   = $clog2(CMAX);

    localparam logic [9:0] C_XC  = 10'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0] C_YC  = 10'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0] C_PC  = 10'((VER_PIXELS - PAD_HEIGHT) / 2);
    localparam logic [9:0] C_XHL = 10'(X_PAD_LEFT + PAD_WIDTH + 1);
    localparam logic [9:0] C_XHR = 10'(X_PAD_RIGHT - BALL_SIZE - 1);
    localparam logic [9:0] C_YMU = 10'(VER_PIXELS - 1 - BALL_SIZE);
    localparam logic [3:0] C_WIN = 4'(WIN_SCORE);

    localparam logic signed [10:0] C_BS   = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_STEP = 11'(BALL_STEP);
    localparam logic signed [10:0] C_PSTP = 11'(PAD_STEP);
    localparam logic signed [10:0] C_PH   = 11'(PAD_HEIGHT);
    localparam logic signed [10:0] C_XMAX = 11'(HOR_PIXELS - 1 - BALL_SIZE);
    localparam logic signed [10:0] C_YMAX = 11'(VER_PIXELS - 1 - BALL_SIZE);
    localparam logic signed [10:0] C_PMAX = 11'(VER_PIXELS - PAD_HEIGHT);
    localparam logic signed [10:0] C_LX   = 11'(X_PAD_LEFT);
    localparam logic signed [10:0] C_LE   = 11'(X_PAD_LEFT + PAD_WIDTH);
    localparam logic signed [10:0] C_RX   = 11'(X_PAD_RIGHT);
    localparam logic signed [10:0] C_RE   = 11'(X_PAD_RIGHT + PAD_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t          r_state;
    logic [9:0]      r_x, r_y, r_pl, r_pr;
    logic [3:0]      r_sl, r_sr;
    logic            r_over, r_dxn, r_dyn;
    logic [CW-1:0]   r_cnt;
    logic            r_vb1, r_vb2, r_arm, r_tick;

    logic signed [10:0] w_x, w_y, w_pl, w_pr, w_nx, w_ny;
    logic w_ov_l, w_ov_r, w_hit_l, w_hit_r;
    logic w_miss_l, w_miss_r, w_miss, w_to_idle;

    function automatic logic [9:0] f_pad(input logic [9:0] p,
                                         input logic up,
                                         input logic dn);
        logic signed [10:0] v;
        v = $signed({1'b0, p});
        if (up && !dn)      v = v - C_PSTP;
        else if (dn && !up) v = v + C_PSTP;
        if (v < 11'sd0)        v = 11'sd0;
        else if (v > C_PMAX)   v = C_PMAX;
        return v[9:0];
    endfunction

    always_comb begin
        w_x      = $signed({1'b0, r_x});
        w_y      = $signed({1'b0, r_y});
        w_pl     = $signed({1'b0, r_pl});
        w_pr     = $signed({1'b0, r_pr});
        w_nx     = r_dxn ? w_x - C_STEP : w_x + C_STEP;
        w_ny     = r_dyn ? w_y - C_STEP : w_y + C_STEP;
        w_ov_l   = (w_y + C_BS >= w_pl) && (w_y <= w_pl + C_PH);
        w_ov_r   = (w_y + C_BS >= w_pr) && (w_y <= w_pr + C_PH);
        w_hit_l  = r_dxn && (w_nx <= C_LE) &&
                   (w_nx + C_BS >= C_LX) && w_ov_l;
        w_hit_r  = !r_dxn && (w_nx + C_BS >= C_RX) &&
                   (w_nx <= C_RE) && w_ov_r;
        w_miss_l = w_nx < 11'sd0;
        w_miss_r = w_nx > C_XMAX;
        w_miss   = !w_hit_l && !w_hit_r && (w_miss_l || w_miss_r);
        w_to_idle = (r_state == S_OVER && bus.start) ||
                    (r_state > S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= C_XC;
            r_y     <= C_YC;
            r_pl    <= C_PC;
            r_pr    <= C_PC;
            r_sl    <= '0;
            r_sr    <= '0;
            r_over  <= 1'b0;
            r_dxn   <= 1'b0;
            r_dyn   <= 1'b0;
            r_cnt   <= '0;
            r_vb1   <= 1'b0;
            r_vb2   <= 1'b0;
            r_arm   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            // arm only after vblnk is seen low, so a level held across reset
            r_vb1  <= bus.vblnk;
            r_vb2  <= r_vb1;
            r_arm  <= r_arm | ~bus.vblnk;
            r_tick <= r_vb1 & ~r_vb2 & r_arm;
            if (w_to_idle) begin
                r_state <= S_IDLE;
                r_x     <= C_XC;
                r_y     <= C_YC;
                r_pl    <= C_PC;
                r_pr    <= C_PC;
                r_sl    <= '0;
                r_sr    <= '0;
                r_over  <= 1'b0;
                r_dxn   <= 1'b0;
                r_dyn   <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_state <= S_SERVE;
                    r_cnt   <= '0;
                    r_dxn   <= 1'b0;
                    r_dyn   <= 1'b0;
                end
            end else if (r_tick && r_state != S_OVER) begin
                r_pl <= f_pad(r_pl, bus.l_up, bus.l_dn);
                r_pr <= f_pad(r_pr, bus.r_up, bus.r_dn);
                unique case (r_state)
                    S_SERVE: begin
                        if (r_cnt == CW'(SERVE_FRAMES - 1)) begin
                            r_state <= S_PLAY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (w_hit_l) begin
                            r_x   <= C_XHL;
                            r_dxn <= 1'b0;
                        end else if (w_hit_r) begin
                            r_x   <= C_XHR;
                            r_dxn <= 1'b1;
                        end else if (w_miss_l) begin
                            r_sr    <= (r_sr == C_WIN) ? r_sr : r_sr + 4'd1;
                            r_dxn   <= 1'b1;
                            r_state <= S_POINT;
                            r_cnt   <= '0;
                        end else if (w_miss_r) begin
                            r_sl    <= (r_sl == C_WIN) ? r_sl : r_sl + 4'd1;
                            r_dxn   <= 1'b0;
                            r_state <= S_POINT;
                            r_cnt   <= '0;
                        end else begin
                            r_x <= w_nx[9:0];
                        end
                        if (!w_miss) begin
                            if (w_ny <= 11'sd0) begin
                                r_y   <= '0;
                                r_dyn <= 1'b0;
                            end else if (w_ny >= C_YMAX) begin
                                r_y   <= C_YMU;
                                r_dyn <= 1'b1;
                            end else begin
                                r_y <= w_ny[9:0];
                            end
                        end
                    end
                    S_POINT: begin
                        if (r_cnt == CW'(POINT_FRAMES - 1)) begin
                            r_cnt <= '0;
                            if (r_sl == C_WIN || r_sr == C_WIN) begin
                                r_state <= S_OVER;
                                r_over  <= 1'b1;
                            end else begin
                                r_state <= S_SERVE;
                                r_x     <= C_XC;
                                r_y     <= C_YC;
                                r_dyn   <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.x_ball      = r_x;
    assign bus.y_ball      = r_y;
    assign bus.y_pad_left  = r_pl;
    assign bus.y_pad_right = r_pr;
    assign bus.score_left  = r_sl;
    assign bus.score_right = r_sr;
    assign bus.game_over   = r_over;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: full scripted match with
// hand-computed trajectories, pad clamps, scoring and reset.
module tb_game_ctl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    game_ctl_if bus ();

    game_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.vblnk = 1'b1;
            repeat (3) @(negedge clk);
            bus.vblnk = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.vblnk = 1'b0;
        bus.start = 1'b0;
        bus.l_up  = 1'b0;
        bus.l_dn  = 1'b0;
        bus.r_up  = 1'b0;
        bus.r_dn  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_state", bus.state, 0);
        chk("rst_x", bus.x_ball, 504);
        chk("rst_y", bus.y_ball, 376);
        chk("rst_pl", bus.y_pad_left, 311);
        chk("rst_pr", bus.y_pad_right, 311);
        chk("rst_sl", bus.score_left, 0);
        chk("rst_sr", bus.score_right, 0);
        chk("rst_go", bus.game_over, 0);

        bus.l_up = 1'b1;
        frames(2);
        chk("idle_pad_hold", bus.y_pad_left, 311);
        chk("idle_stay", bus.state, 0);
        bus.l_up = 1'b0;

        // rally 1: serve right, right pad parked low, left buttons cancel
        pulse_start();
        chk("start_serve", bus.state, 1);
        bus.r_dn = 1'b1;
        bus.l_up = 1'b1;
        bus.l_dn = 1'b1;
        frames(59);
        chk("serve_59", bus.state, 1);
        chk("serve_x_held", bus.x_ball, 504);
        frames(1);
        chk("serve_60_play", bus.state, 2);
        chk("pr_clamp_hi", bus.y_pad_right, 623);
        chk("pl_both_btn", bus.y_pad_left, 311);
        chk("play0_x", bus.x_ball, 504);
        chk("play0_y", bus.y_ball, 376);
        bus.r_dn = 1'b0;
        bus.l_up = 1'b0;
        bus.l_dn = 1'b0;
        frames(1);
        chk("t1_x", bus.x_ball, 508);
        chk("t1_y", bus.y_ball, 380);
        frames(92);
        chk("t93_y", bus.y_ball, 748);
        frames(1);
        chk("t94_wall_y", bus.y_ball, 752);
        chk("t94_x", bus.x_ball, 880);
        frames(1);
        chk("t95_y", bus.y_ball, 748);
        frames(19);
        chk("t114_x", bus.x_ball, 960);
        chk("t114_y", bus.y_ball, 672);
        frames(1);
        chk("rhit_x", bus.x_ball, 963);
        chk("rhit_y", bus.y_ball, 668);
        frames(1);
        chk("rhit_next_x", bus.x_ball, 959);
        frames(239);
        chk("t355_x", bus.x_ball, 3);
        chk("t355_state", bus.state, 2);
        frames(1);
        chk("lmiss_state", bus.state, 3);
        chk("lmiss_sr", bus.score_right, 1);
        chk("lmiss_x", bus.x_ball, 3);
        chk("lmiss_y", bus.y_ball, 292);

        bus.l_up = 1'b1;
        frames(89);
        chk("point_89", bus.state, 3);
        chk("pl_clamp_lo", bus.y_pad_left, 0);
        frames(1);
        chk("point_serve", bus.state, 1);
        chk("recentre_x", bus.x_ball, 504);
        chk("recentre_y", bus.y_ball, 376);
        chk("pl_stay_lo", bus.y_pad_left, 0);
        bus.l_up = 1'b0;

        // rally 2: serve left, left pad at top so ball slips past
        frames(60);
        chk("r2_play", bus.state, 2);
        frames(115);
        chk("r2_pass_pad_x", bus.x_ball, 44);
        frames(12);
        chk("r2_state", bus.state, 3);
        chk("r2_sr", bus.score_right, 2);
        chk("r2_x", bus.x_ball, 0);
        bus.l_dn = 1'b1;
        frames(90);
        chk("r2_serve", bus.state, 1);
        chk("r2_pl", bus.y_pad_left, 540);
        bus.l_dn = 1'b0;

        // rally 3: serve left into left pad, then miss on the right
        frames(60);
        frames(114);
        chk("r3_x48", bus.x_ball, 48);
        chk("r3_y", bus.y_ball, 672);
        frames(1);
        chk("lhit_x", bus.x_ball, 46);
        frames(1);
        chk("lhit_next_x", bus.x_ball, 50);
        frames(239);
        chk("r3_x1006", bus.x_ball, 1006);
        frames(1);
        chk("r3_state", bus.state, 3);
        chk("r3_sl", bus.score_left, 1);
        chk("r3_x", bus.x_ball, 1006);
        bus.r_up = 1'b1;
        frames(90);
        chk("r3_pr", bus.y_pad_right, 83);
        chk("r3_serve", bus.state, 1);
        bus.r_up = 1'b0;

        for (int k = 2; k <= 8; k++) begin
            frames(187);
            chk("rk_state", bus.state, 3);
            chk("rk_sl", bus.score_left, k);
            frames(90);
        end

        frames(187);
        chk("win_state", bus.state, 3);
        chk("win_sl", bus.score_left, 9);
        chk("win_x", bus.x_ball, 1008);
        chk("win_go_pre", bus.game_over, 0);
        frames(89);
        chk("win_hold", bus.state, 3);
        frames(1);
        chk("over_state", bus.state, 4);
        chk("over_go", bus.game_over, 1);

        bus.l_dn = 1'b1;
        frames(3);
        chk("over_pl_frz", bus.y_pad_left, 540);
        chk("over_x_frz", bus.x_ball, 1008);
        chk("over_stay", bus.state, 4);
        bus.l_dn = 1'b0;

        pulse_start();
        chk("restart_state", bus.state, 0);
        chk("restart_sl", bus.score_left, 0);
        chk("restart_sr", bus.score_right, 0);
        chk("restart_go", bus.game_over, 0);
        chk("restart_x", bus.x_ball, 504);
        chk("restart_pl", bus.y_pad_left, 311);

        pulse_start();
        chk("g2_serve", bus.state, 1);
        frames(60);
        chk("g2_play", bus.state, 2);
        frames(5);
        chk("g2_x", bus.x_ball, 524);
        chk("g2_y", bus.y_ball, 396);

        // asynchronous reset between edges, vblnk high across release
        #2;
        bus.vblnk = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_x", bus.x_ball, 504);
        chk("arst_y", bus.y_ball, 376);
        chk("arst_pr", bus.y_pad_right, 311);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("arst_serve", bus.state, 1);
        repeat (4) @(negedge clk);
        bus.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        frames(59);
        chk("arst_no_tick", bus.state, 1);
        frames(1);
        chk("arst_play", bus.state, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_ctl.md
GAME_CTL -- requirements
Module: game_ctl

Interface
REQ-001 Parameters (name, default, meaning): HOR_PIXELS, 1024, visible width; VER_PIXELS, 768, visible height; BALL_SIZE, 15, ball box extent; PAD_HEIGHT, 145, pad height; PAD_WIDTH, 15, pad width; X_PAD_LEFT, 30, left pad x; X_PAD_RIGHT, 979, right pad x; BALL_STEP, 4, ball pixels/frame per axis; PAD_STEP, 6, pad pixels/frame; SERVE_FRAMES, 60, serve delay; POINT_FRAMES, 90, post-point hold; WIN_SCORE, 9, winning score.
REQ-002 Ports (name, direction, width, meaning): clk in 1 pixel clock; rst_n in 1 reset, asynchronous, active-low; vblnk in 1 vertical blank from timing chain; start in 1 start/restart request (synchronous level); l_up, l_dn, r_up, r_dn in 1 each, pad controls (synchronous levels); x_ball out 10 ball box left; y_ball out 10 ball box top; y_pad_left out 10 left pad top; y_pad_right out 10 right pad top; score_left out 4; score_right out 4; game_over out 1; state out 3 FSM encoding for debug.

Function
REQ-003 Frame tick: tick SHALL pulse one cycle on the cycle after a 0->1 transition of vblnk as registered internally; all position, counter and FSM updates SHALL occur only on tick, except start handling in IDLE/GAME_OVER.
REQ-004 Outputs SHALL be registered; a tick-driven update SHALL be visible on outputs the cycle after tick.
REQ-005 FSM states: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; other codes SHALL return to IDLE next cycle.
REQ-006 IDLE: ball at ((HOR_PIXELS-BALL_SIZE)/2,(VER_PIXELS-BALL_SIZE)/2)=(504,376), pads at (VER_PIXELS-PAD_HEIGHT)/2=311, scores 0; start=1 on any cycle -> SERVE with frame counter cleared.
REQ-007 SERVE: ball held at center; frame counter increments per tick; on tick where count reaches SERVE_FRAMES-1 -> PLAY, counter cleared.
REQ-008 Serve direction: dx toward the side that lost the last point (rightward after IDLE), dy positive (down).
REQ-009 PLAY, per tick: next position = current + dx*BALL_STEP, dy*BALL_STEP, computed in 11-bit signed arithmetic; no unsigned wrap permitted.
REQ-010 Wall: next y <= 0 -> y_ball=0, dy=+1; next y >= VER_PIXELS-1-BALL_SIZE (752) -> y_ball=752, dy=-1.
REQ-011 Left pad hit: dx=-1, next x <= X_PAD_LEFT+PAD_WIDTH (45), next x+BALL_SIZE >= X_PAD_LEFT, and vertical overlap (y+BALL_SIZE >= y_pad_left and y <= y_pad_left+PAD_HEIGHT) -> x_ball=46, dx=+1.
REQ-012 Right pad hit: mirror of REQ-011; next x+BALL_SIZE >= X_PAD_RIGHT -> x_ball=X_PAD_RIGHT-BALL_SIZE-1 (963), dx=-1.
REQ-013 Miss: next x < 0 -> score_right+1, POINT; next x > HOR_PIXELS-1-BALL_SIZE -> score_left+1, POINT; ball frozen at last legal position.
REQ-014 Simultaneous wall and pad events in one tick SHALL both apply (both axes reflected); pad hit SHALL take precedence over miss.
REQ-015 POINT: hold POINT_FRAMES ticks; then either score == WIN_SCORE -> OVER, else -> SERVE with ball recentred.
REQ-016 OVER: game_over=1, positions frozen; start=1 -> IDLE.
REQ-017 Pads move in SERVE, PLAY, POINT only: up subtracts PAD_STEP, down adds; both or neither asserted -> no move; clamp to [0, VER_PIXELS-PAD_HEIGHT] = [0,623].
REQ-018 Scores SHALL saturate at WIN_SCORE and never wrap.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, REQ-006 positions, scores 0, game_over 0, dx=+1, dy=+1, counters 0, registered vblnk 0, regardless of state or mid-frame timing.
REQ-020 After rst_n release, no tick SHALL occur until a fresh 0->1 vblnk edge is seen.

Verification
REQ-021 Reset then start=1 and 60 vblnk edges -> state SERVE to PLAY on 60th tick; next tick x_ball=508, y_ball=380.
REQ-022 PLAY, ball y=750, dy=+1 -> next tick y_ball=752, dy=-1; following tick y_ball=748.
REQ-023 Ball at x=48 moving left, y_pad_left=311, y_ball=376 -> next tick x_ball=46, dx=+1; with y_pad_left=0 instead -> ball continues, later score_right=1, state POINT.
REQ-024 l_up held 100 ticks from 311 -> y_pad_left reaches 0 and stays; l_up and l_dn together -> unchanged.
REQ-025 Force score_left=8, left scores -> score_left=9, POINT then OVER after 90 ticks, game_over=1; start -> IDLE, scores 0.
REQ-026 Assert rst_n=0 mid-PLAY between clock edges -> outputs at IDLE values immediately, no tick until next vblnk rising edge.
